// File: rtl/calc_operand_sequencer.sv
// Keypad-driven operand sequencer for the 4-bit signed comparator: collects A and B,
// captures the comparator flags and holds them for the display. Optional negate key: CALC_NEGATE_KEY_EN.
module calc_operand_sequencer #(
  parameter int ACK_TIMEOUT = 0,
  parameter int TMR_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [1:0] key_cmd,
  input  logic [3:0] key_value,
  input  logic       cmp_greater,
  input  logic       cmp_equal,
  input  logic       cmp_less,
  input  logic       result_ack,
  output logic [3:0] operand1,
  output logic [3:0] operand2,
  output logic [1:0] entry_phase,
  output logic       operands_valid,
  output logic       result_valid,
  output logic [2:0] result_flags,
  output logic       cmp_error,
  output logic       timeout_pulse,
  output logic       neg_ovf_pulse
);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    SETTLE  = 2'b10,
    RESULT  = 2'b11
  } phase_e;

  localparam logic [1:0] CMD_DIGIT  = 2'b00;
  localparam logic [1:0] CMD_ENTER  = 2'b01;
  localparam logic [1:0] CMD_CLEAR  = 2'b10;
  localparam bit               TMO_EN   = (ACK_TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TMO_LAST = TMO_EN ? TMR_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

  phase_e           state_q, state_d;
  logic [3:0]       operand1_q, operand1_d;
  logic [3:0]       operand2_q, operand2_d;
  logic [2:0]       flags_q, flags_d;
  logic             result_valid_q, result_valid_d;
  logic             operands_valid_q, operands_valid_d;
  logic             cmp_error_q, cmp_error_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic             neg_ovf_q, neg_ovf_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic       clear_s, digit_s, enter_s, tmo_hit_s;
  logic [2:0] flags_in_s;

  function automatic logic is_onehot3(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

`ifdef CALC_NEGATE_KEY_EN
  logic negate_s;
  assign negate_s = key_valid && (key_cmd == 2'b11);

  // -8 has no positive counterpart: keep it and report the overflow bit
  function automatic logic [4:0] negate_op(input logic [3:0] v);
    if (v == 4'b1000) return {v, 1'b1};
    else              return {4'd0 - v, 1'b0};
  endfunction
`endif

  assign clear_s    = key_valid && (key_cmd == CMD_CLEAR);
  assign digit_s    = key_valid && (key_cmd == CMD_DIGIT);
  assign enter_s    = key_valid && (key_cmd == CMD_ENTER);
  assign flags_in_s = {cmp_greater, cmp_equal, cmp_less};
  // An ack on the last allowed cycle pre-empts the timeout
  assign tmo_hit_s  = TMO_EN && (state_q == RESULT) && !result_ack && (tmr_q == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ENTER_A;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_s) begin
      state_d = ENTER_A;
    end else begin
      case (state_q)
        ENTER_A: if (enter_s) state_d = ENTER_B; else state_d = ENTER_A;
        ENTER_B: if (enter_s) state_d = SETTLE;  else state_d = ENTER_B;
        SETTLE:  state_d = RESULT;
        RESULT:  if (result_ack || tmo_hit_s) state_d = ENTER_A; else state_d = RESULT;
        default: state_d = ENTER_A;
      endcase
    end
  end

  always_comb begin
    operand1_d      = operand1_q;
    operand2_d      = operand2_q;
    flags_d         = flags_q;
    cmp_error_d     = cmp_error_q;
    tmr_d           = tmr_q;
    timeout_pulse_d = 1'b0;
    neg_ovf_d       = 1'b0;
    if (clear_s) begin
      operand1_d  = 4'd0;
      operand2_d  = 4'd0;
      cmp_error_d = 1'b0;
      tmr_d       = '0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (digit_s) operand1_d = key_value;
`ifdef CALC_NEGATE_KEY_EN
          else if (negate_s) {operand1_d, neg_ovf_d} = negate_op(operand1_q);
`endif
          else operand1_d = operand1_q;
        end
        ENTER_B: begin
          if (digit_s) operand2_d = key_value;
`ifdef CALC_NEGATE_KEY_EN
          else if (negate_s) {operand2_d, neg_ovf_d} = negate_op(operand2_q);
`endif
          else operand2_d = operand2_q;
        end
        SETTLE: begin
          flags_d = flags_in_s;
          if (!is_onehot3(flags_in_s)) cmp_error_d = 1'b1;
          else                         cmp_error_d = cmp_error_q;
        end
        RESULT: begin
          if (result_ack) begin
            tmr_d = '0;
          end else if (tmo_hit_s) begin
            tmr_d           = '0;
            timeout_pulse_d = 1'b1;
          end else if (TMO_EN) begin
            tmr_d = tmr_q + TMR_ONE;
          end else begin
            tmr_d = tmr_q;
          end
        end
        default: tmr_d = '0;
      endcase
    end
    result_valid_d   = (state_d == RESULT);
    operands_valid_d = (state_d == SETTLE) || (state_d == RESULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand1_q       <= 4'd0;
      operand2_q       <= 4'd0;
      flags_q          <= 3'b000;
      result_valid_q   <= 1'b0;
      operands_valid_q <= 1'b0;
      cmp_error_q      <= 1'b0;
      timeout_pulse_q  <= 1'b0;
      neg_ovf_q        <= 1'b0;
      tmr_q            <= '0;
    end else begin
      operand1_q       <= operand1_d;
      operand2_q       <= operand2_d;
      flags_q          <= flags_d;
      result_valid_q   <= result_valid_d;
      operands_valid_q <= operands_valid_d;
      cmp_error_q      <= cmp_error_d;
      timeout_pulse_q  <= timeout_pulse_d;
      neg_ovf_q        <= neg_ovf_d;
      tmr_q            <= tmr_d;
    end
  end

  assign operand1       = operand1_q;
  assign operand2       = operand2_q;
  assign entry_phase    = state_q;
  assign operands_valid = operands_valid_q;
  assign result_valid   = result_valid_q;
  assign result_flags   = flags_q;
  assign cmp_error      = cmp_error_q;
  assign timeout_pulse  = timeout_pulse_q;
  assign neg_ovf_pulse  = neg_ovf_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Bench for calc_operand_sequencer: directed scenarios plus randomized keys checked
// against a behavioural model; a comparator model closes the loop.
module tb_calc_operand_sequencer;
  localparam int TMO = 4;
`ifdef CALC_NEGATE_KEY_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif
  localparam logic [1:0] D = 2'b00, E = 2'b01, C = 2'b10, N = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [1:0] key_cmd = 2'b00;
  logic [3:0] key_value = 4'd0;
  logic       result_ack = 1'b0;
  logic       cmp_greater, cmp_equal, cmp_less;
  logic [3:0] operand1, operand2;
  logic [1:0] entry_phase;
  logic       operands_valid, result_valid, cmp_error, timeout_pulse, neg_ovf_pulse;
  logic [2:0] result_flags;
  logic       force_bad = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int         m_phase;
  logic [3:0] m_a, m_b;
  logic [2:0] m_flags;
  bit         m_rv, m_err, m_tp, m_np;
  int         m_tmr;

  logic [17:0] obs;
  assign obs = {entry_phase, operand1, operand2, operands_valid, result_valid,
                result_flags, cmp_error, timeout_pulse, neg_ovf_pulse};

  calc_operand_sequencer #(.ACK_TIMEOUT(TMO), .TMR_W(8)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_cmd(key_cmd),
    .key_value(key_value), .cmp_greater(cmp_greater), .cmp_equal(cmp_equal),
    .cmp_less(cmp_less), .result_ack(result_ack), .operand1(operand1),
    .operand2(operand2), .entry_phase(entry_phase), .operands_valid(operands_valid),
    .result_valid(result_valid), .result_flags(result_flags), .cmp_error(cmp_error),
    .timeout_pulse(timeout_pulse), .neg_ovf_pulse(neg_ovf_pulse)
  );

  always #5 clk = ~clk;

  // signed comparator, optionally forced into an illegal greater+less output
  always_comb begin
    if (force_bad) begin
      {cmp_greater, cmp_equal, cmp_less} = 3'b101;
    end else begin
      cmp_greater = $signed(operand1) > $signed(operand2);
      cmp_equal   = operand1 == operand2;
      cmp_less    = $signed(operand1) < $signed(operand2);
    end
  end

  function automatic logic [2:0] expect_flags();
    int ia, ib;
    if (force_bad) return 3'b101;
    ia = int'($signed(m_a));
    ib = int'($signed(m_b));
    return {ia > ib, ia == ib, ia < ib};
  endfunction

  function automatic logic [17:0] exp_vec();
    return {2'(m_phase), m_a, m_b, m_phase >= 2, m_rv, m_flags, m_err, m_tp, m_np};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_a = 4'd0; m_b = 4'd0; m_flags = 3'b000;
    m_rv = 1'b0; m_err = 1'b0; m_tp = 1'b0; m_np = 1'b0; m_tmr = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] cmd, input logic [3:0] val, input bit ack);
    logic [3:0] t;
    m_tp = 1'b0;
    m_np = 1'b0;
    if (v && cmd == C) begin
      m_phase = 0; m_a = 4'd0; m_b = 4'd0; m_rv = 1'b0; m_err = 1'b0; m_tmr = 0;
    end else if (m_phase <= 1) begin
      if (v && cmd == D) begin
        if (m_phase == 0) m_a = val; else m_b = val;
      end else if (v && cmd == E) begin
        m_phase = m_phase + 1;
      end else if (v && cmd == N && NEG_EN) begin
        t = (m_phase == 0) ? m_a : m_b;
        if (t == 4'b1000) m_np = 1'b1;
        else t = 4'((16 - int'(t)) % 16);
        if (m_phase == 0) m_a = t; else m_b = t;
      end
    end else if (m_phase == 2) begin
      m_flags = expect_flags();
      if ($countones(m_flags) != 1) m_err = 1'b1;
      m_rv = 1'b1;
      m_phase = 3;
    end else begin
      if (ack) begin
        m_phase = 0; m_rv = 1'b0; m_tmr = 0;
      end else begin
        m_tmr = m_tmr + 1;
        if (m_tmr == TMO) begin
          m_phase = 0; m_rv = 1'b0; m_tmr = 0; m_tp = 1'b1;
        end
      end
    end
  endtask

  task automatic tick(input bit v, input logic [1:0] cmd, input logic [3:0] val, input bit ack);
    @(negedge clk);
    key_valid = v; key_cmd = cmd; key_value = val; result_ack = ack;
    @(posedge clk);
    model_step(v, cmd, val, ack);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 18'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    tick(1, D, 4'd3, 0); tick(1, E, 4'd0, 0); tick(1, D, 4'd14, 0); tick(1, E, 4'd0, 0);
    n_checks++;
    if (entry_phase !== 2'b10 || result_valid !== 1'b0 || operands_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_settle phase=%b rv=%b ov=%b want 10/0/1", entry_phase, result_valid, operands_valid);
    end
    tick(0, D, 4'd0, 0);
    n_checks++;
    if (result_valid !== 1'b1 || result_flags !== 3'b100 || operand1 !== 4'd3 || operand2 !== 4'd14) begin
      n_errors++;
      $display("FAIL basic_result rv=%b flags=%b a=%0d b=%0d want 1/100/3/14", result_valid, result_flags, operand1, operand2);
    end
    tick(0, D, 4'd0, 0);
    n_checks++;
    if (obs !== exp_vec() || result_flags !== 3'b100) begin
      n_errors++;
      $display("FAIL basic_hold got=%b want=%b", obs, exp_vec());
    end
    tick(0, D, 4'd0, 1);
    n_checks++;
    if (entry_phase !== 2'b00 || result_valid !== 1'b0 || operand1 !== 4'd3) begin
      n_errors++;
      $display("FAIL basic_ack phase=%b rv=%b a=%0d want 00/0/3", entry_phase, result_valid, operand1);
    end
  endtask

  task automatic test_overwrite();
    tick(1, D, 4'd5, 0); tick(1, D, 4'd7, 0); tick(1, E, 4'd0, 0);
    tick(1, D, 4'd7, 0); tick(1, E, 4'd0, 0); tick(0, D, 4'd0, 0);
    n_checks++;
    if (operand1 !== 4'd7 || result_flags !== 3'b010) begin
      n_errors++;
      $display("FAIL overwrite_equal a=%0d flags=%b want 7/010", operand1, result_flags);
    end
    tick(0, D, 4'd0, 1);
    tick(1, E, 4'd0, 0); tick(1, D, 4'd8, 0); tick(1, E, 4'd0, 0); tick(0, D, 4'd0, 0);
    n_checks++;
    if (operand2 !== 4'd8 || result_flags !== 3'b100 || obs !== exp_vec()) begin
      n_errors++;
      $display("FAIL overwrite_minus8 b=%0d flags=%b want 8/100", operand2, result_flags);
    end
    tick(0, D, 4'd0, 1);
  endtask

  task automatic test_error();
    force_bad = 1'b1;
    tick(1, E, 4'd0, 0); tick(1, E, 4'd0, 0); tick(0, D, 4'd0, 0);
    force_bad = 1'b0;
    n_checks++;
    if (cmp_error !== 1'b1 || result_flags !== 3'b101) begin
      n_errors++;
      $display("FAIL error_set err=%b flags=%b want 1/101", cmp_error, result_flags);
    end
    tick(0, D, 4'd0, 1); tick(1, E, 4'd0, 0); tick(1, E, 4'd0, 0); tick(0, D, 4'd0, 0);
    n_checks++;
    if (cmp_error !== 1'b1 || result_flags !== 3'b100) begin
      n_errors++;
      $display("FAIL error_sticky err=%b flags=%b want 1/100", cmp_error, result_flags);
    end
    tick(1, C, 4'd0, 0);
    n_checks++;
    if (cmp_error !== 1'b0 || entry_phase !== 2'b00 || operand1 !== 4'd0 || operand2 !== 4'd0) begin
      n_errors++;
      $display("FAIL error_clear err=%b phase=%b a=%0d b=%0d want 0/00/0/0", cmp_error, entry_phase, operand1, operand2);
    end
  endtask

  task automatic test_timeout();
    int exit_at, pulse_at, pulses;
    tick(1, D, 4'd1, 0); tick(1, E, 4'd0, 0); tick(1, D, 4'd2, 0); tick(1, E, 4'd0, 0);
    tick(0, D, 4'd0, 0);
    exit_at = -1; pulse_at = -1; pulses = 0;
    for (int i = 1; i <= 10 && exit_at < 0; i++) begin
      tick(0, D, 4'd0, 0);
      if (timeout_pulse === 1'b1) begin pulses++; pulse_at = i; end
      if (result_valid !== 1'b1) exit_at = i;
    end
    n_checks++;
    if (exit_at != TMO || pulse_at != TMO || pulses != 1) begin
      n_errors++;
      $display("FAIL timeout_fire exit=%0d pulse=%0d count=%0d want %0d/%0d/1", exit_at, pulse_at, pulses, TMO, TMO);
    end
    tick(0, D, 4'd0, 0);
    n_checks++;
    if (timeout_pulse !== 1'b0 || entry_phase !== 2'b00) begin
      n_errors++;
      $display("FAIL timeout_one_shot pulse=%b phase=%b want 0/00", timeout_pulse, entry_phase);
    end
    tick(1, E, 4'd0, 0); tick(1, E, 4'd0, 0); tick(0, D, 4'd0, 0);
    repeat (TMO - 1) tick(0, D, 4'd0, 0);
    tick(0, D, 4'd0, 1);
    n_checks++;
    if (timeout_pulse !== 1'b0 || result_valid !== 1'b0 || entry_phase !== 2'b00) begin
      n_errors++;
      $display("FAIL timeout_ack_wins pulse=%b rv=%b phase=%b want 0/0/00", timeout_pulse, result_valid, entry_phase);
    end
  endtask

  task automatic test_clear();
    tick(1, E, 4'd0, 0); tick(1, E, 4'd0, 0); tick(0, D, 4'd0, 0);
    tick(1, C, 4'd0, 1);
    n_checks++;
    if (operand1 !== 4'd0 || operand2 !== 4'd0 || entry_phase !== 2'b00 || result_valid !== 1'b0 || operands_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_in_result got=%b want=%b", obs, exp_vec());
    end
    tick(1, D, 4'd5, 0); tick(1, E, 4'd0, 0); tick(1, D, 4'd6, 0);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (operand1 !== 4'd0 || operand2 !== 4'd0 || entry_phase !== 2'b00 || result_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset a=%0d b=%0d phase=%b rv=%b want 0/0/00/0", operand1, operand2, entry_phase, result_valid);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_negate();
    tick(1, D, 4'd3, 0); tick(1, N, 4'd0, 0);
    n_checks++;
    if (operand1 !== (NEG_EN ? 4'd13 : 4'd3) || neg_ovf_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL negate_three a=%0d ovf=%b want %0d/0", operand1, neg_ovf_pulse, NEG_EN ? 13 : 3);
    end
    tick(1, D, 4'd8, 0); tick(1, N, 4'd0, 0);
    n_checks++;
    if (operand1 !== 4'd8 || neg_ovf_pulse !== NEG_EN) begin
      n_errors++;
      $display("FAIL negate_minus8 a=%0d ovf=%b want 8/%b", operand1, neg_ovf_pulse, NEG_EN);
    end
    tick(0, D, 4'd0, 0);
    n_checks++;
    if (neg_ovf_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL negate_one_shot ovf=%b want 0", neg_ovf_pulse);
    end
    tick(1, C, 4'd0, 0);
  endtask

  task automatic test_random();
    int r;
    bit v, ack;
    logic [1:0] cmd;
    for (int i = 0; i < 600; i++) begin
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 15);
      cmd = (r < 6) ? D : (r < 12) ? E : (r < 13) ? C : N;
      ack = $urandom_range(0, 3) == 0;
      force_bad = $urandom_range(0, 9) == 0;
      tick(v, cmd, 4'($urandom_range(0, 15)), ack);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL random_step%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    force_bad = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overwrite();
    test_error();
    test_timeout();
    test_clear();
    test_negate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_operand_sequencer.md
Name: calc_operand_sequencer

Overview:
- Front-end sequencer for the 4-bit signed compare path. Collects two 4-bit two's-complement operands from the keypad command stream and drives them as registered outputs into the four-bit signed comparator.
- Captures the comparator's greater/equal/less flags into a result register and holds them for the display stage using a valid/ack handshake.
- Sits between the keypad decoder (upstream) and the display/result logic (downstream). Wraps the comparator on both sides.

Parameters:
- ACK_TIMEOUT, 0, cycles to wait in RESULT for result_ack before returning to ENTER_A on its own; 0 disables the timeout.
- TMR_W, 8, width of the timeout counter; ACK_TIMEOUT must be < 2^TMR_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_cmd/key_value are valid this cycle
- key_cmd  in  2  00 digit, 01 enter, 10 clear, 11 negate (used only with the optional feature)
- key_value  in  4  operand nibble, two's complement; used only for digit commands
- cmp_greater  in  1  greater flag from the comparator
- cmp_equal  in  1  equal flag from the comparator
- cmp_less  in  1  less flag from the comparator
- result_ack  in  1  display has consumed the result
- operand1  out  4  registered operand A, drives the comparator
- operand2  out  4  registered operand B, drives the comparator
- entry_phase  out  2  00 ENTER_A, 01 ENTER_B, 10 SETTLE, 11 RESULT
- operands_valid  out  1  high in SETTLE and RESULT
- result_valid  out  1  high in RESULT
- result_flags  out  3  {greater, equal, less} captured at the end of SETTLE
- cmp_error  out  1  sticky; set when the captured flags are not one-hot
- timeout_pulse  out  1  one-cycle pulse when the RESULT timeout fires
- neg_ovf_pulse  out  1  one-cycle pulse when -8 is negated (tied 0 without the optional feature)

Behaviour:
- Reset (async, any state):
  - state ENTER_A; operand1 = operand2 = 0.
  - result_flags = 000; result_valid, operands_valid, cmp_error, timeout_pulse, neg_ovf_pulse = 0.
  - Timeout counter = 0.
- Commands act only when key_valid = 1. Clear acts in every state; all other commands are ignored in SETTLE and RESULT.
- Clear, any state, next cycle:
  - state ENTER_A; operand1 = operand2 = 0.
  - result_valid = 0; cmp_error = 0; counter = 0.
- ENTER_A:
  - digit: operand1 <= key_value; repeated digits overwrite.
  - enter: go to ENTER_B; operand2 keeps its previous value.
- ENTER_B:
  - digit: operand2 <= key_value.
  - enter: go to SETTLE.
- SETTLE, exactly one cycle:
  - Operands are stable and the comparator output is settled.
  - At the clock edge: result_flags <= {cmp_greater, cmp_equal, cmp_less}; result_valid <= 1; go to RESULT.
  - If the sampled flags are not exactly one-hot, cmp_error <= 1.
- Latency: enter in ENTER_B at edge t -> SETTLE during cycle t+1 -> result_valid = 1 from edge t+2.
- RESULT:
  - result_flags are held stable until exit.
  - result_ack = 1: next cycle result_valid = 0 and state ENTER_A; operands are retained, so the next entry overwrites them.
  - Ack and clear in the same cycle: clear wins (operands zeroed).
  - With ACK_TIMEOUT > 0: the counter increments each RESULT cycle without ack. When it reaches ACK_TIMEOUT, the transition is the same as an ack and timeout_pulse = 1 for one cycle.
  - Ack in the same cycle as expiry: treated as an ack; no timeout_pulse.
  - The counter is zeroed on every RESULT exit.
- Flags arriving outside SETTLE are ignored.
- No arithmetic beyond the capture; operands are passed through unchanged.

Optional Feature:
- Macro: CALC_NEGATE_KEY_EN.
- Defined: key_cmd = 11 in ENTER_A or ENTER_B replaces the active operand with its two's complement (4-bit, wraps).
  - Negating 4'b1000 leaves it at 4'b1000 and raises neg_ovf_pulse for one cycle.
  - Example: 3 -> 13 (-3).
- Not defined: key_cmd = 11 is ignored in all states; neg_ovf_pulse is tied 0.

Test Plan:
- Comparator instantiated in the bench. Keys: digit 3, enter, digit 14 (-2), enter -> result_valid rises 2 edges after the second enter, result_flags = 100; ack -> ENTER_A next cycle.
- Digits 5 then 7 in ENTER_A, enter, digit 7, enter -> operand1 = 7, result_flags = 010; repeat with operand2 = 8 (-8) -> 100.
- Force cmp_greater = cmp_less = 1 during SETTLE -> cmp_error = 1, and it stays 1 through ack until a clear command.
- ACK_TIMEOUT = 4, hold ack low -> timeout_pulse on the 4th RESULT cycle, result_valid low next cycle; separately, ack on the expiry cycle -> no pulse.
- Clear during RESULT, and reset asserted mid-ENTER_B -> operands 0, ENTER_A, result_valid 0 immediately (reset asynchronously, clear next edge).
- CALC_NEGATE_KEY_EN: digit 3, negate -> operand1 = 13; digit 8, negate -> operand1 = 8 with neg_ovf_pulse; without the macro, negate leaves the operand unchanged.
